// File: rtl/tick_clock_divider.sv
// tick_clock_divider: multi-channel, run-time programmable clock divider.
//
// Each channel counts system clock cycles up to its divisor and toggles a
// square clock at each terminal count, giving a half-period of div+1 cycles.
// A one-cycle tick accompanies every rising edge of that clock. Divisor
// writes are shadowed and only take effect at a terminal count, while the
// channel is disabled, or on resync, so a running clock never sees a runt
// half-period.
//
// Ports:
//   clock_in    system clock, all logic on its rising edge
//   reset_n     asynchronous active-low reset
//   enable      per-channel run enable (held count/level when low)
//   resync      synchronous strobe, restarts every channel in phase
//   load_valid  one-cycle divisor write strobe
//   load_sel    target channel of the write (out-of-range writes are dropped)
//   load_div    new divisor value
//   clock_out   divided square clocks, registered
//   tick        one-cycle pulse in the cycle clock_out rises, registered
//   pending     a shadowed divisor is waiting to be applied
module tick_clock_divider #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned DEFAULT_DIV = 12_000_000
) (
  input  logic                clock_in,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] enable,
  input  logic                resync,
  input  logic                load_valid,
  input  logic [2:0]          load_sel,
  input  logic [WIDTH-1:0]    load_div,
  output logic [CHANNELS-1:0] clock_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending
);

  localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             pend_q, pend_d;
    logic             wr;
    logic             tc;
    logic [WIDTH-1:0] apply_div;

    // Only indices below CHANNELS have a decoder, so a write to a
    // non-existent channel matches nothing and has no effect.
    assign wr = load_valid && (load_sel == 3'(i));
    assign tc = (cnt_q == div_q);

    // Divisor that takes over when a load is applied this cycle: a write in
    // the same cycle bypasses the shadow, otherwise a pending shadow is used.
    always_comb begin
      apply_div = div_q;
      if (wr) begin
        apply_div = load_div;
      end else if (pend_q) begin
        apply_div = shadow_q;
      end
    end

    always_comb begin
      cnt_d    = cnt_q;
      div_d    = div_q;
      shadow_d = shadow_q;
      clk_d    = clk_q;
      tick_d   = 1'b0;
      pend_d   = pend_q;

      if (wr) begin
        shadow_d = load_div;
      end

      if (resync) begin
        cnt_d  = '0;
        clk_d  = 1'b0;
        div_d  = apply_div;
        pend_d = 1'b0;
      end else if (!enable[i]) begin
        if (wr) begin
          pend_d = 1'b1;
        end else if (pend_q) begin
          // Frozen channel: apply right away, restarting the half-period
          // if the held count already lies beyond the new terminal value.
          div_d  = shadow_q;
          pend_d = 1'b0;
          if (cnt_q > shadow_q) begin
            cnt_d = '0;
          end
        end
      end else if (tc) begin
        cnt_d  = '0;
        clk_d  = ~clk_q;
        tick_d = ~clk_q;
        div_d  = apply_div;
        pend_d = 1'b0;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
        if (wr) begin
          pend_d = 1'b1;
        end
      end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q    <= '0;
        div_q    <= RESET_DIV;
        shadow_q <= RESET_DIV;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
        pend_q   <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        div_q    <= div_d;
        shadow_q <= shadow_d;
        clk_q    <= clk_d;
        tick_q   <= tick_d;
        pend_q   <= pend_d;
      end
    end

    assign clock_out[i] = clk_q;
    assign tick[i]      = tick_q;
    assign pending[i]   = pend_q;
  end

endmodule

// File: tb/tb_tick_clock_divider.sv
// Self-checking bench for tick_clock_divider (2 channels, 8-bit, reset div 3).
// The reference model tracks each channel as "edges left until the next
// toggle" plus half-period lengths, rather than as a counter/divisor pair.
module tb_tick_clock_divider;
  localparam int CH = 2;
  localparam int W  = 8;
  localparam int DD = 3;

  logic          clock_in   = 1'b0;
  logic          reset_n    = 1'b0;
  logic [CH-1:0] enable     = '0;
  logic          resync     = 1'b0;
  logic          load_valid = 1'b0;
  logic [2:0]    load_sel   = '0;
  logic [W-1:0]  load_div   = '0;
  logic [CH-1:0] clock_out;
  logic [CH-1:0] tick;
  logic [CH-1:0] pending;

  tick_clock_divider #(
    .WIDTH      (W),
    .CHANNELS   (CH),
    .DEFAULT_DIV(DD)
  ) dut (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .enable    (enable),
    .resync    (resync),
    .load_valid(load_valid),
    .load_sel  (load_sel),
    .load_div  (load_div),
    .clock_out (clock_out),
    .tick      (tick),
    .pending   (pending)
  );

  always #5 clock_in = ~clock_in;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: m_left = enabled edges until the toggle edge (inclusive),
  // m_len = current half-period length, m_next = shadowed half-period length.
  int m_left [CH];
  int m_len  [CH];
  int m_next [CH];
  bit m_lvl  [CH];
  bit m_tick [CH];
  bit m_pend [CH];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_left[c] = DD + 1;
      m_len[c]  = DD + 1;
      m_next[c] = DD + 1;
      m_lvl[c]  = 1'b0;
      m_tick[c] = 1'b0;
      m_pend[c] = 1'b0;
    end
  endtask

  // Predicts the state after the coming rising edge from the current inputs.
  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      bit wr;
      int wlen;
      int done;
      wr   = load_valid && (int'(load_sel) == c);
      wlen = int'(load_div) + 1;
      if (resync) begin
        if (wr) m_len[c] = wlen;
        else if (m_pend[c]) m_len[c] = m_next[c];
        if (wr) m_next[c] = wlen;
        m_pend[c] = 1'b0;
        m_left[c] = m_len[c];
        m_lvl[c]  = 1'b0;
        m_tick[c] = 1'b0;
      end else if (!enable[c]) begin
        m_tick[c] = 1'b0;
        if (wr) begin
          m_next[c] = wlen;
          m_pend[c] = 1'b1;
        end else if (m_pend[c]) begin
          done      = m_len[c] - m_left[c];
          m_len[c]  = m_next[c];
          m_pend[c] = 1'b0;
          m_left[c] = (done >= m_len[c]) ? m_len[c] : m_len[c] - done;
        end
      end else if (m_left[c] == 1) begin
        m_lvl[c]  = ~m_lvl[c];
        m_tick[c] = m_lvl[c];
        if (wr) begin
          m_len[c]  = wlen;
          m_next[c] = wlen;
        end else if (m_pend[c]) begin
          m_len[c] = m_next[c];
        end
        m_pend[c] = 1'b0;
        m_left[c] = m_len[c];
      end else begin
        m_left[c]--;
        m_tick[c] = 1'b0;
        if (wr) begin
          m_next[c] = wlen;
          m_pend[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [CH-1:0] e_clk, e_tick, e_pend;
    for (int c = 0; c < CH; c++) begin
      e_clk[c]  = m_lvl[c];
      e_tick[c] = m_tick[c];
      e_pend[c] = m_pend[c];
    end
    chk("clock_out", int'(clock_out), int'(e_clk));
    chk("tick", int'(tick), int'(e_tick));
    chk("pending", int'(pending), int'(e_pend));
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step_cycle();
    if (reset_n) model_step();
    else model_reset();
    @(posedge clock_in);
    #1;
    compare_all();
    @(negedge clock_in);
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_clk", int'(clock_out), 0);
    chk("async_rst_tick", int'(tick), 0);
    chk("async_rst_pend", int'(pending), 0);
    model_reset();
    @(negedge clock_in);
    step_cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    int first_tick, second_tick;
    int tq[$];
    int ticks_off;
    bit prev;
    int guard;

    model_reset();
    #1;
    chk("reset_clk", int'(clock_out), 0);
    chk("reset_tick", int'(tick), 0);
    chk("reset_pend", int'(pending), 0);
    @(negedge clock_in);
    step_cycle();
    step_cycle();

    // Reset divisor 3: rises on edges 4 and 12 after release.
    reset_n = 1'b1;
    enable  = 2'b11;
    first_tick  = -1;
    second_tick = -1;
    for (int k = 1; k <= 20; k++) begin
      step_cycle();
      if (tick[0]) begin
        if (first_tick < 0) first_tick = k;
        else if (second_tick < 0) second_tick = k;
      end
    end
    chk("first_tick_cycle", first_tick, 4);
    chk("tick_period", second_tick - first_tick, 8);

    // Mid half-period write of div 1 to ch0.
    step_cycle();
    load_valid = 1'b1; load_sel = 3'd0; load_div = 8'd1;
    step_cycle();
    load_valid = 1'b0;
    chk("pend0_after_write", int'(pending[0]), 1);
    prev = clock_out[0];
    for (int k = 1; k <= 16; k++) begin
      step_cycle();
      if (clock_out[0] != prev) tq.push_back(k);
      prev = clock_out[0];
    end
    chk("toggles_seen", (tq.size() >= 4) ? 1 : 0, 1);
    if (tq.size() >= 4) begin
      chk("half_period_a", tq[2] - tq[1], 2);
      chk("half_period_b", tq[3] - tq[2], 2);
    end

    // Write div 0 to ch1 exactly at its terminal count.
    guard = 0;
    while (m_left[1] != 1 && guard < 20) begin
      step_cycle();
      guard++;
    end
    chk("ch1_tc_found", (guard < 20) ? 1 : 0, 1);
    load_valid = 1'b1; load_sel = 3'd1; load_div = 8'd0;
    step_cycle();
    load_valid = 1'b0;
    chk("pend1_at_tc_write", int'(pending[1]), 0);
    prev = clock_out[1];
    step_cycle();
    chk("div0_half_period", (clock_out[1] != prev) ? 1 : 0, 1);

    // Freeze ch0 for 10 cycles.
    step_cycle();
    enable[0] = 1'b0;
    ticks_off = 0;
    for (int k = 0; k < 10; k++) begin
      step_cycle();
      if (tick[0]) ticks_off++;
    end
    chk("ticks_while_disabled", ticks_off, 0);
    enable[0] = 1'b1;
    for (int k = 0; k < 7; k++) step_cycle();

    // Resync with ch1 loaded to div 1 in the same cycle; both rise together.
    resync = 1'b1;
    load_valid = 1'b1; load_sel = 3'd1; load_div = 8'd1;
    step_cycle();
    resync = 1'b0;
    load_valid = 1'b0;
    chk("resync_clk_low", int'(clock_out), 0);
    step_cycle();
    step_cycle();
    chk("resync_joint_tick", int'(tick), 3);

    // Out-of-range write leaves everything alone.
    load_valid = 1'b1; load_sel = 3'd5; load_div = 8'd7;
    step_cycle();
    load_valid = 1'b0;
    chk("oob_write_pend", int'(pending), 0);
    for (int k = 0; k < 6; k++) step_cycle();

    // Asynchronous reset mid-count, then back to the reset divisor.
    async_reset();
    first_tick = -1;
    for (int k = 1; k <= 6; k++) begin
      step_cycle();
      if (tick[0] && first_tick < 0) first_tick = k;
    end
    chk("post_reset_first_tick", first_tick, 4);

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < CH; c++) enable[c] = ($urandom_range(0, 99) < 85);
      resync     = ($urandom_range(0, 99) < 2);
      load_valid = ($urandom_range(0, 99) < 15);
      load_sel   = 3'($urandom_range(0, 7));
      load_div   = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 999) < 3) begin
        resync = 1'b0;
        load_valid = 1'b0;
        async_reset();
      end else begin
        step_cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/tick_clock_divider.md
Name: tick_clock_divider

Overview:
- Multi-channel, run-time programmable clock divider for the game CPU and display timing (gravity tick, input debounce, blink).
- Each channel produces a divided square clock and a one-cycle tick pulse on every rising edge of that clock.
- The divisor can be changed safely while the channel is running: new values are shadowed and take effect only at a terminal count, so no runt pulses occur.
- Includes per-channel enable and a global resync that phase-aligns all channels.

Parameters:
- WIDTH, 32, counter and divisor width in bits.
- CHANNELS, 2, number of independent divider channels (1..8).
- DEFAULT_DIV, 12_000_000, divisor loaded into every channel at reset.

Ports:
- clock_in  input  1  system clock; all logic is on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  CHANNELS  per-channel run enable.
- resync  input  1  synchronous strobe; restarts all channels in phase.
- load_valid  input  1  divisor write strobe, one cycle.
- load_sel  input  3  target channel index for the write.
- load_div  input  WIDTH  new divisor value.
- clock_out  output  CHANNELS  divided square clocks, registered.
- tick  output  CHANNELS  one-cycle pulse, registered; asserted in the same cycle clock_out[i] rises.
- pending  output  CHANNELS  a shadowed divisor is waiting to be applied.

Behaviour:
- Reset (async, reset_n=0): all counters 0; div_reg and shadow = DEFAULT_DIV; clock_out=0; tick=0; pending=0.
- Per channel i, when enable[i]=1:
  - Terminal count (TC) occurs when cnt==div_reg.
  - At TC: cnt←0 and clock_out[i] toggles. Otherwise cnt←cnt+1.
  - Half-period is div_reg+1 cycles; full period is 2*(div_reg+1).
  - div_reg=0 gives clock_in/2.
- tick[i]=1 for exactly one cycle, when clock_out[i] goes 0→1; otherwise tick[i]=0.
- When enable[i]=0: cnt and clock_out[i] hold; tick[i]=0. On re-enable, counting resumes from the held count.
- Divisor load:
  - When load_valid=1 and load_sel<CHANNELS, shadow[load_sel]←load_div and pending[load_sel]←1.
  - If load_sel≥CHANNELS, the write is ignored with no side effects.
- Load application:
  - At the TC of a channel with pending=1: div_reg←shadow, pending←0. The new value governs the half-period that starts after this TC.
  - If the channel is disabled, a load is applied on the next cycle with pending=1, without waiting for a TC.
  - If a write and a TC hit the same channel in the same cycle, the newly written value is bypassed into div_reg at that TC and pending ends 0.
  - Back-to-back writes before a TC: last write wins; pending stays 1.
- resync=1: for every channel, cnt←0, clock_out←0, tick←0, and any pending shadow is applied immediately (pending←0). resync takes priority over TC and enable.
  - A load write in the same cycle as resync is applied directly to div_reg.
- Counter width: cnt and div_reg are WIDTH bits with no overflow; cnt never exceeds div_reg.
  - If div_reg is lowered by a load while cnt>new value, this cannot occur because loads apply only at TC, disable, or resync, all of which leave cnt at 0 or frozen. A disabled channel with cnt>new div_reg clears cnt to 0 when the load applies.
- reset_n asserted mid-operation returns everything to reset values immediately; the first TC after reset_n deasserts is DEFAULT_DIV+1 cycles later.

Test Plan:
- Reset, CHANNELS=2, DEFAULT_DIV=3, enable=2'b11 → each clock_out toggles every 4 cycles (period 8); tick pulses once per 8 cycles, aligned with the rising edge; pending=0.
- Running ch0 at div 3; write load_div=1 to ch0 mid half-period → pending[0]=1 until the next TC, then clears; following half-periods are 2 cycles; no half-period shorter than 2 cycles is observed.
- Write in the exact TC cycle of ch1 with load_div=0 → next half-period is 1 cycle (clock_in/2); pending[1] never observed high.
- enable[0]=0 for 10 cycles mid-count → clock_out[0] and the count freeze, tick[0]=0; after re-enable, the remaining cycles of the half-period complete exactly.
- ch0 and ch1 at different phases; pulse resync → both clock_out go 0 the next cycle; both rise together div+1 cycles later with simultaneous tick pulses.
- Write with load_sel=5 → no change to any shadow, pending or output. Pulse reset_n low mid-count → outputs 0 immediately (asynchronous); period returns to DEFAULT_DIV.
